universal_shift_reg: RTL and testbench



---
 rtl/usr_pkg.sv | 24 ++
 rtl/usr_step.sv | 47 ++++
 rtl/universal_shift_reg.sv | 89 ++++++++
 tb/tb_universal_shift_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared mode encodings and FSM state type for the universal shift register.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Modes that move bits and can therefore be repeated as a multi-step operation.
    function automatic logic is_shift(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// Single-step combinational datapath: computes the next register value and carry for one op.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             sil,
    input  logic             sir,
    input  logic [WIDTH-1:0] p,
    input  logic             cout,
    output logic [WIDTH-1:0] next_q,
    output logic             next_cout
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        next_q    = q;
        next_cout = cout;
        case (op)
            MODE_SHR: begin
                next_q    = {sir, q[WIDTH-1:1]};
                next_cout = q[0];
            end
            MODE_SHL: begin
                next_q    = {q[WIDTH-2:0], sil};
                next_cout = q[WIDTH-1];
            end
            MODE_LOAD: next_q = p;
            MODE_ROR: begin
                next_q    = {q[0], q[WIDTH-1:1]};
                next_cout = q[0];
            end
            MODE_ROL: begin
                next_q    = {q[WIDTH-2:0], q[WIDTH-1]};
                next_cout = q[WIDTH-1];
            end
            MODE_ASR: begin
                next_q    = {q[WIDTH-1], q[WIDTH-1:1]};
                next_cout = q[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with per-cycle legacy modes and a start/busy/done multi-step shift.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] p,
    input  logic             sir,
    input  logic             sil,
    input  logic [AMT_W-1:0] amt,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       op_r;
    logic [2:0]       op_sel;
    logic [WIDTH-1:0] next_q;
    logic             next_cout;

    // The latched op drives the datapath while busy so live mode changes are ignored.
    assign op_sel = (state == ST_BUSY) ? op_r : mode;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q        (q),
        .op       (op_sel),
        .sil      (sil),
        .sir      (sir),
        .p        (p),
        .cout     (cout),
        .next_q   (next_q),
        .next_cout(next_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_r  <= MODE_HOLD;
            q     <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_shift(mode) && (amt != '0)) begin
                            op_r  <= mode;
                            cnt   <= amt;
                            state <= ST_BUSY;
                            busy  <= 1'b1;
                        end else begin
                            if (mode == MODE_LOAD) begin
                                q <= p;
                            end
                            done <= 1'b1;
                        end
                    end else begin
                        q    <= next_q;
                        cout <= next_cout;
                    end
                end
                ST_BUSY: begin
                    q    <= next_q;
                    cout <= next_cout;
                    cnt  <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8.
module tb_universal_shift_reg;
    import usr_pkg::*;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             clk;
    logic             clear;
    logic [2:0]       mode;
    logic [WIDTH-1:0] p;
    logic             sir;
    logic             sil;
    logic [AMT_W-1:0] amt;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             cout;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    universal_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk  (clk),
        .clear(clear),
        .mode (mode),
        .p    (p),
        .sir  (sir),
        .sil  (sil),
        .amt  (amt),
        .start(start),
        .q    (q),
        .cout (cout),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Full output snapshot: q, cout, busy, done.
    task automatic check_all(input string tag, input logic [7:0] eq, input logic ec,
                             input logic eb, input logic ed);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".cout"}, 32'(cout), 32'(ec));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear = 1'b1;
        mode  = MODE_LOAD;
        p     = 8'hA5;
        sir   = 1'b0;
        sil   = 1'b0;
        amt   = '0;
        start = 1'b0;

        // Reset and legacy per-cycle modes
        step();
        step();
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        step();
        check_all("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        mode = MODE_SHR; sir = 1'b0;
        step();
        check_all("shr", 8'h52, 1'b1, 1'b0, 1'b0);
        mode = MODE_SHL; sil = 1'b1;
        step();
        check_all("shl", 8'hA5, 1'b0, 1'b0, 1'b0);
        mode = MODE_HOLD;
        step();
        check_all("hold", 8'hA5, 1'b0, 1'b0, 1'b0);
        mode = MODE_RSVD;
        step();
        check_all("rsvd", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Multi-step ROL by 3 from 0x81
        mode = MODE_LOAD; p = 8'h81;
        step();
        check("load_81", 32'(q), 32'h81);
        mode = MODE_ROL; amt = 4'd3; start = 1'b1;
        step();
        check_all("rol_start", 8'h81, 1'b0, 1'b1, 1'b0);
        start = 1'b0; mode = MODE_HOLD;
        step();
        check_all("rol_s1", 8'h03, 1'b1, 1'b1, 1'b0);
        step();
        check_all("rol_s2", 8'h06, 1'b0, 1'b1, 1'b0);
        step();
        check_all("rol_s3", 8'h0C, 1'b0, 1'b0, 1'b1);
        step();
        check_all("rol_after", 8'h0C, 1'b0, 1'b0, 1'b0);

        // Multi-step ASR by 9 (amt >= WIDTH saturates to sign fill)
        mode = MODE_LOAD; p = 8'h80;
        step();
        mode = MODE_ASR; amt = 4'd9; start = 1'b1;
        step();
        check_all("asr_start", 8'h80, 1'b0, 1'b1, 1'b0);
        start = 1'b0; mode = MODE_HOLD;
        step();
        check_all("asr_s1", 8'hC0, 1'b0, 1'b1, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            step();
            check("asr_mid.done", 32'(done), 32'h0);
        end
        check_all("asr_s8", 8'hFF, 1'b1, 1'b1, 1'b0);
        step();
        check_all("asr_s9", 8'hFF, 1'b1, 1'b0, 1'b1);

        // amt=0 start completes immediately without busy
        mode = MODE_SHR; amt = 4'd0; start = 1'b1;
        step();
        check_all("amt0", 8'hFF, 1'b1, 1'b0, 1'b1);
        start = 1'b0; mode = MODE_HOLD;
        step();
        check_all("amt0_after", 8'hFF, 1'b1, 1'b0, 1'b0);

        // LOAD with start performs one load and pulses done
        mode = MODE_LOAD; p = 8'h3C; amt = 4'd5; start = 1'b1;
        step();
        check_all("load_start", 8'h3C, 1'b1, 1'b0, 1'b1);
        start = 1'b0; mode = MODE_HOLD;
        step();
        check_all("load_start_after", 8'h3C, 1'b1, 1'b0, 1'b0);

        // 4-step SHR with sir=1; conflicting inputs while busy must be ignored
        mode = MODE_SHR; sir = 1'b1; amt = 4'd4; start = 1'b1;
        step();
        check_all("shr4_start", 8'h3C, 1'b1, 1'b1, 1'b0);
        mode = MODE_LOAD; p = 8'hFF; amt = 4'd2; start = 1'b1;
        step();
        check_all("shr4_s1", 8'h9E, 1'b0, 1'b1, 1'b0);
        step();
        check_all("shr4_s2", 8'hCF, 1'b0, 1'b1, 1'b0);
        step();
        check_all("shr4_s3", 8'hE7, 1'b1, 1'b1, 1'b0);
        mode = MODE_HOLD; start = 1'b0;
        step();
        check_all("shr4_s4", 8'hF3, 1'b1, 1'b0, 1'b1);

        // Mid-operation clear aborts without done
        mode = MODE_SHL; sil = 1'b0; amt = 4'd5; start = 1'b1;
        step();
        start = 1'b0; mode = MODE_HOLD;
        step();
        check("abort_s1.q", 32'(q), 32'hE6);
        step();
        check_all("abort_s2", 8'hCC, 1'b1, 1'b1, 1'b0);
        #2;
        clear = 1'b1;
        #1;
        check_all("abort_clear", 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        check_all("abort_held", 8'h00, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        step();
        check_all("abort_release", 8'h00, 1'b0, 1'b0, 1'b0);

        // New operation after abort, then a start accepted in the done cycle
        mode = MODE_LOAD; p = 8'h01;
        step();
        mode = MODE_SHL; sil = 1'b0; amt = 4'd2; start = 1'b1;
        step();
        check_all("post_start", 8'h01, 1'b0, 1'b1, 1'b0);
        start = 1'b0; mode = MODE_HOLD;
        step();
        check_all("post_s1", 8'h02, 1'b0, 1'b1, 1'b0);
        mode = MODE_ROR; amt = 4'd1; start = 1'b1;
        step();
        check_all("post_s2", 8'h04, 1'b0, 1'b0, 1'b1);
        step();
        check_all("restart_edge", 8'h04, 1'b0, 1'b1, 1'b0);
        start = 1'b0; mode = MODE_HOLD;
        step();
        check_all("restart_s1", 8'h02, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
